tdm_mux: RTL
============

TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of each data channel and of y.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL have localparam SEL_W = $clog2(CHANNELS): width of sel and y_ch.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port din, input, CHANNELS*WIDTH bits: channel k occupies din[k*WIDTH +: WIDTH].
REQ-007 SHALL have port ch_en, input, CHANNELS bits: per-channel enable, used only in scan mode.
REQ-008 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto scan.
REQ-009 SHALL have port sel, input, SEL_W bits: channel index in manual mode; scan start point on scan entry.
REQ-010 SHALL have port advance, input, 1 bit: scan step strobe.
REQ-011 SHALL have port y, output, WIDTH bits: registered selected data.
REQ-012 SHALL have port y_valid, output, 1 bit: y holds legal channel data.
REQ-013 SHALL have port y_ch, output, SEL_W bits: index of the channel currently driving y.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, MANUAL, SCAN.
REQ-015 SHALL leave IDLE on the first cycle after reset, going to MANUAL if mode=0 and to SCAN if mode=1.
REQ-016 SHALL move from MANUAL to SCAN when mode=1 and load ptr = sel, or ptr = 0 if sel >= CHANNELS.
REQ-017 SHALL move from SCAN to MANUAL when mode=0, discarding ptr.
REQ-018 SHALL, in MANUAL, register y = din[sel], y_ch = sel and y_valid = 1, all with 1-cycle latency from sel/din.
REQ-019 SHALL, in MANUAL with sel >= CHANNELS, register y = 0, y_ch = 0 and y_valid = 0.
REQ-020 SHALL, in SCAN, register y = din[ptr], y_ch = ptr and y_valid = 1 every cycle, with 1-cycle latency.
REQ-021 SHALL, in SCAN with advance=1, step ptr to ptr+1, wrapping from CHANNELS-1 to 0; with advance=0, ptr holds.
REQ-022 SHALL, on the mode-switch cycle, select output per the old state; the new state governs from the next cycle.
REQ-023 SHALL, in IDLE, hold y = 0 and y_valid = 0.
REQ-024 SHALL give advance no effect outside SCAN.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, force state = IDLE, ptr = 0, y = 0, y_valid = 0 and y_ch = 0.
REQ-026 SHALL give rst priority over mode, advance and any in-progress scan, including a mid-scan reset.

Configuration
REQ-027 SHALL compile in channel skipping when macro TDM_MUX_SKIP_EN is defined.
REQ-028 SHALL, with TDM_MUX_SKIP_EN, on advance in SCAN, move ptr to the next channel after ptr, in wrap order, whose ch_en bit is 1.
REQ-029 SHALL, with TDM_MUX_SKIP_EN, on advance when ptr's own channel is the only enabled channel, keep ptr unchanged.
REQ-030 SHALL, with TDM_MUX_SKIP_EN, in SCAN when ch_en is all 0, hold ptr, drive y = 0 and drive y_valid = 0.
REQ-031 SHALL, with TDM_MUX_SKIP_EN, on scan entry where the loaded ptr channel is disabled, drive y_valid = 0 until the first advance.
REQ-032 SHALL, without TDM_MUX_SKIP_EN, ignore ch_en entirely and use the plain wrap of REQ-021.

Verification
REQ-033 SHALL cover manual select: CHANNELS=4, WIDTH=8, din = {8'hD3,8'hC2,8'hB1,8'hA0}, mode=0, sel=2 -> next cycle y=8'hC2, y_ch=2, y_valid=1.
REQ-034 SHALL cover scan wrap: mode=1, sel=3, advance=1 for 5 cycles -> y_ch sequence 3,0,1,2,3 and y follows the matching din channel.
REQ-035 SHALL cover illegal select: CHANNELS=3, mode=0, sel=3 -> y=0, y_valid=0.
REQ-036 SHALL cover mid-scan reset: rst=1 for 1 cycle during scan at ptr=2 -> y=0, y_valid=0, y_ch=0, state IDLE; after release with mode=1, scan restarts from sel.
REQ-037 SHALL cover skip (TDM_MUX_SKIP_EN defined): ch_en=4'b1010, advance held 1 -> y_ch alternates 1,3,1,3; ch_en=0 -> y_valid=0 with ptr held.
REQ-038 SHALL cover skip (TDM_MUX_SKIP_EN undefined): ch_en=4'b1010, advance held 1 -> y_ch sequence 0,1,2,3.

Source files
------------

// File: rtl/tdm_mux.sv
// Time-division multiplexer: manual channel select or auto scan with a registered output.
// Optional macro TDM_MUX_SKIP_EN: the scan skips channels whose ch_en bit is 0.
module tdm_mux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      advance,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          y_ch
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W:0]   CH_CNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(CHANNELS - 1);

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [WIDTH-1:0]   y_q;
  logic               y_valid_q;
  logic [SEL_W-1:0]   y_ch_q;

  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   ptr_data;
  logic               sel_legal;
  logic [SEL_W-1:0]   load_ptr;
  logic [SEL_W-1:0]   ptr_step_d;
  logic               scan_valid;

  // Compare-based muxes keep out-of-range indices (non power-of-two CHANNELS) harmless.
  always_comb begin
    sel_data = '0;
    ptr_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k))   sel_data = din[k*WIDTH +: WIDTH];
      if (ptr_q == SEL_W'(k)) ptr_data = din[k*WIDTH +: WIDTH];
    end
  end

  assign sel_legal = ({1'b0, sel} < CH_CNT);
  assign load_ptr  = sel_legal ? sel : '0;

`ifdef TDM_MUX_SKIP_EN
  logic found;

  // Nearest enabled channel after ptr in wrap order; ptr holds if no other channel is enabled.
  always_comb begin
    ptr_step_d = ptr_q;
    found      = 1'b0;
    for (int k = 1; k < CHANNELS; k++) begin
      if (!found && ch_en[(int'(ptr_q) + k) % CHANNELS]) begin
        ptr_step_d = SEL_W'((int'(ptr_q) + k) % CHANNELS);
        found      = 1'b1;
      end
    end
    scan_valid = ch_en[ptr_q];
  end
`else
  logic unused_ch_en;
  assign unused_ch_en = ^ch_en;
  assign ptr_step_d   = (ptr_q == LAST) ? '0 : ptr_q + SEL_W'(1);
  assign scan_valid   = 1'b1;
`endif

  // Output selection follows the current state; a mode change takes effect next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          y_q       <= '0;
          y_valid_q <= 1'b0;
          y_ch_q    <= '0;
          if (mode) begin
            state_q <= SCAN;
            ptr_q   <= load_ptr;
          end else begin
            state_q <= MANUAL;
          end
        end
        MANUAL: begin
          y_q       <= sel_legal ? sel_data : '0;
          y_valid_q <= sel_legal;
          y_ch_q    <= load_ptr;
          if (mode) begin
            state_q <= SCAN;
            ptr_q   <= load_ptr;
          end
        end
        SCAN: begin
          y_q       <= scan_valid ? ptr_data : '0;
          y_valid_q <= scan_valid;
          y_ch_q    <= ptr_q;
          if (advance) ptr_q <= ptr_step_d;
          if (!mode)   state_q <= MANUAL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_ch    = y_ch_q;

endmodule
